// File: rtl/ci_pkg.sv
// Shared definitions for the *_vector_runner family: FSM states and the verdict encoding.
package ci_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        CHECK,
        FINISH
    } state_t;

    typedef logic [1:0] verdict_t;

    localparam verdict_t VERDICT_NONE = 2'b00;
    localparam verdict_t VERDICT_PASS = 2'b01;
    localparam verdict_t VERDICT_FAIL = 2'b10;

    function automatic logic verdict_done(input verdict_t v);
        return (v == VERDICT_PASS) || (v == VERDICT_FAIL);
    endfunction

endpackage

// File: rtl/ci_lat_counter.sv
// Loadable down-counter that covers the operator latency; load value is the LAT parameter.
module ci_lat_counter #(
    parameter int LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CW'(LAT);
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/eq_vector_runner.sv
// Walks a vector table through an a/b -> y operator and keeps a sticky pass/fail verdict.
// Each vector takes LOAD + (LAT+1) WAIT + CHECK = LAT+3 cycles.
module eq_vector_runner #(
    parameter int WIDTH   = 8,
    parameter int NUM_VEC = 16,
    parameter int LAT     = 1,
    parameter int IDXW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [IDXW-1:0]  vec_idx,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic             vec_exp,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [IDXW-1:0]  fail_idx
);

    import ci_pkg::*;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VEC - 1);

    state_t           state_reg;
    logic [IDXW-1:0]  vec_idx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             exp_reg;
    logic             busy_reg;
    verdict_t         verdict_reg;
    logic [IDXW-1:0]  fail_idx_reg;
    logic             lat_zero;

    ci_lat_counter #(
        .LAT (LAT)
    ) u_lat_counter (
        .clock (clock),
        .reset (reset),
        .load  (state_reg == LOAD),
        .dec   (state_reg == WAIT),
        .zero  (lat_zero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            vec_idx_reg  <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            exp_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            verdict_reg  <= VERDICT_NONE;
            fail_idx_reg <= '0;
        end else begin
            case (state_reg)
                // FINISH holds everything until a fresh start; busy is low in both states
                IDLE, FINISH: begin
                    if (start) begin
                        state_reg    <= LOAD;
                        vec_idx_reg  <= '0;
                        busy_reg     <= 1'b1;
                        verdict_reg  <= VERDICT_NONE;
                        fail_idx_reg <= '0;
                    end
                end
                LOAD: begin
                    a_reg     <= vec_a;
                    b_reg     <= vec_b;
                    exp_reg   <= vec_exp;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (lat_zero) begin
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (y != exp_reg) begin
                        verdict_reg  <= VERDICT_FAIL;
                        fail_idx_reg <= vec_idx_reg;
                        busy_reg     <= 1'b0;
                        state_reg    <= FINISH;
                    end else if (vec_idx_reg == LAST_IDX) begin
                        verdict_reg <= VERDICT_PASS;
                        busy_reg    <= 1'b0;
                        state_reg   <= FINISH;
                    end else begin
                        vec_idx_reg <= vec_idx_reg + 1'b1;
                        state_reg   <= LOAD;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign vec_idx  = vec_idx_reg;
    assign a        = a_reg;
    assign b        = b_reg;
    assign busy     = busy_reg;
    assign pass     = (verdict_reg == VERDICT_PASS);
    assign fail     = (verdict_reg == VERDICT_FAIL);
    assign done     = verdict_done(verdict_reg);
    assign fail_idx = fail_idx_reg;

endmodule

// File: tb/tb_eq_vector_runner.sv
// Scoreboard bench: two runners (LAT=1 registered comparator, LAT=0 combinational) share one table.
module tb_eq_vector_runner;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int IW   = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #500 clock = ~clock;

    logic [W-1:0] tab_a [N];
    logic [W-1:0] tab_b [N];
    logic         tab_exp [N];

    logic [1:0]    start_v;
    logic [IW-1:0] vec_idx_v [2];
    logic [W-1:0]  a_v [2];
    logic [W-1:0]  b_v [2];
    logic [IW-1:0] fidx_v [2];
    logic [1:0]    y_v, busy_v, done_v, pass_v, fail_v;

    eq_vector_runner #(.WIDTH(W), .NUM_VEC(N), .LAT(1), .IDXW(IW)) u_run0 (
        .clock(clock), .reset(reset), .start(start_v[0]), .vec_idx(vec_idx_v[0]),
        .vec_a(tab_a[vec_idx_v[0]]), .vec_b(tab_b[vec_idx_v[0]]), .vec_exp(tab_exp[vec_idx_v[0]]),
        .a(a_v[0]), .b(b_v[0]), .y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .fail(fail_v[0]), .fail_idx(fidx_v[0])
    );

    eq_vector_runner #(.WIDTH(W), .NUM_VEC(N), .LAT(0), .IDXW(IW)) u_run1 (
        .clock(clock), .reset(reset), .start(start_v[1]), .vec_idx(vec_idx_v[1]),
        .vec_a(tab_a[vec_idx_v[1]]), .vec_b(tab_b[vec_idx_v[1]]), .vec_exp(tab_exp[vec_idx_v[1]]),
        .a(a_v[1]), .b(b_v[1]), .y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .fail(fail_v[1]), .fail_idx(fidx_v[1])
    );

    // operator under test: one-cycle registered equality, and a purely combinational one
    always @(posedge clock) y_v[0] <= (a_v[0] == b_v[0]);
    assign y_v[1] = (a_v[1] == b_v[1]);

    typedef struct {
        int       unit;
        bit       pass;
        int       fidx;
        int       a;
        int       b;
        int       done_cyc;
    } exp_t;

    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: pops an expectation whenever a runner raises done
    logic [1:0] done_prev = 2'b00;
    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (reset) begin
                chk($sformatf("u%0d_pass_and_fail", u), int'(pass_v[u] & fail_v[u]), 0);
                chk($sformatf("u%0d_done_is_verdict", u), int'(done_v[u]), int'(pass_v[u] | fail_v[u]));
            end
            if (done_v[u] && !done_prev[u]) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("u%0d_unexpected_done", u), 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("unit", u, e.unit);
                    chk("pass", int'(pass_v[u]), int'(e.pass));
                    chk("fail", int'(fail_v[u]), int'(!e.pass));
                    chk("fail_idx", int'(fidx_v[u]), e.fidx);
                    chk("busy_at_done", int'(busy_v[u]), 0);
                    chk("a_at_done", int'(a_v[u]), e.a);
                    chk("b_at_done", int'(b_v[u]), e.b);
                    chk("done_cycle", cyc, e.done_cyc);
                    $display("run unit=%0d pass=%0d fail=%0d fail_idx=%0d a=%0d b=%0d cyc=%0d",
                             u, pass_v[u], fail_v[u], fidx_v[u], a_v[u], b_v[u], cyc);
                end
            end
        end
        done_prev <= done_v;
    end

    task automatic set_vec(input int i, input int va, input int vb, input bit ve);
        tab_a[i]   = W'(va);
        tab_b[i]   = W'(vb);
        tab_exp[i] = ve;
    endtask

    // reference model: first vector whose equality disagrees with its expectation stops the run
    task automatic run(input int unit, input bit mid_start);
        exp_t e;
        int   fi;
        int   k;
        int   lat;
        int   t;
        lat = (unit == 0) ? 1 : 0;
        fi  = -1;
        for (int i = 0; i < N; i++) begin
            if (fi < 0 && ((tab_a[i] == tab_b[i]) != tab_exp[i])) fi = i;
        end
        k          = (fi < 0) ? N : fi + 1;
        e.unit     = unit;
        e.pass     = (fi < 0);
        e.fidx     = (fi < 0) ? 0 : fi;
        e.a        = int'(tab_a[k-1]);
        e.b        = int'(tab_b[k-1]);
        e.done_cyc = cyc + 1 + k * (lat + 3);
        sbq.push_back(e);
        start_v[unit] = 1'b1;
        @(negedge clock);
        start_v[unit] = 1'b0;
        if (mid_start) begin
            repeat (5) @(negedge clock);
            start_v[unit] = 1'b1;
            @(negedge clock);
            start_v[unit] = 1'b0;
        end
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("run_timeout", sbq.size(), 0);
        sbq.delete();
        repeat (3) @(negedge clock);
        chk("a_held", int'(a_v[unit]), e.a);
        chk("b_held", int'(b_v[unit]), e.b);
        chk("done_held", int'(done_v[unit]), 1);
    endtask

    task automatic rand_table();
        for (int i = 0; i < N; i++) begin
            int va;
            int vb;
            va = int'($urandom_range(0, 255));
            vb = ($urandom_range(0, 1) == 1) ? va : int'($urandom_range(0, 255));
            set_vec(i, va, vb, va == vb);
        end
        if ($urandom_range(0, 1) == 1) begin
            int f;
            f = int'($urandom_range(0, N - 1));
            tab_exp[f] = ~tab_exp[f];
        end
    endtask

    initial begin
        start_v = 2'b00;
        for (int i = 0; i < N; i++) set_vec(i, 0, 0, 1'b1);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", int'(busy_v[u]), 0);
            chk("rst_done", int'(done_v[u]), 0);
            chk("rst_pass", int'(pass_v[u]), 0);
            chk("rst_fail", int'(fail_v[u]), 0);
            chk("rst_a", int'(a_v[u]), 0);
            chk("rst_b", int'(b_v[u]), 0);
            chk("rst_vec_idx", int'(vec_idx_v[u]), 0);
            chk("rst_fail_idx", int'(fidx_v[u]), 0);
        end
        reset = 1'b1;
        @(negedge clock);

        set_vec(0, 5, 5, 1'b1);
        set_vec(1, 3, 4, 1'b0);
        set_vec(2, 255, 255, 1'b1);
        set_vec(3, 0, 128, 1'b0);
        run(0, 1'b0);
        run(0, 1'b1);
        run(1, 1'b0);

        set_vec(2, 7, 7, 1'b0);
        run(0, 1'b0);
        run(1, 1'b0);

        set_vec(2, 255, 255, 1'b1);
        set_vec(0, 9, 9, 1'b0);
        run(0, 1'b0);
        set_vec(0, 5, 5, 1'b1);
        set_vec(3, 1, 2, 1'b1);
        run(1, 1'b0);
        set_vec(3, 0, 128, 1'b0);

        // abort mid-run during WAIT of vector 1, then a clean run
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        repeat (5) @(negedge clock);
        chk("busy_before_abort", int'(busy_v[0]), 1);
        chk("vec_idx_before_abort", int'(vec_idx_v[0]), 1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_done", int'(done_v[0]), 0);
        chk("abort_a", int'(a_v[0]), 0);
        chk("abort_b", int'(b_v[0]), 0);
        chk("abort_vec_idx", int'(vec_idx_v[0]), 0);
        @(negedge clock);
        run(0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            rand_table();
            run(r % 2, (r % 5) == 3);
        end

        chk("queue_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
